// File: rtl/conv_layer_pkg.sv
// -----------------------------------------------------------------------------
// conv_layer_pkg
// Shared definitions for the conv layer input path. It holds the row buffer
// command encoding, the load-finished ack level, the default word width, the
// feeder FSM state encoding and the address generator operation codes.
// -----------------------------------------------------------------------------
package conv_layer_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Row buffer command encoding.
    typedef enum logic [1:0] {
        CMD_INIT = 2'd0,
        CMD_IDLE = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_READ = 2'd3
    } buf_cmd_t;

    // Level that the buffer drives on buf_ack once a row load has finished.
    localparam logic ACK_LOAD_FIN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_ACK,
        ST_READ,
        ST_DONE
    } feeder_state_t;

    // Per-cycle operation that the feeder requests from the address generator.
    typedef enum logic [2:0] {
        ADDR_HOLD,
        ADDR_CLEAR,     // new frame: row = col = 0
        ADDR_BASE,      // entering FETCH: address column 0 of the current row
        ADDR_PREFETCH,  // FETCH -> LOAD: address column 1
        ADDR_STEP,      // mid-row LOAD cycle: col+1, address col+2
        ADDR_NEXT_ROW   // final LOAD cycle: col = 0, row+1
    } addr_op_t;

endpackage

// File: rtl/conv_layer_feeder_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_layer_feeder_addr_gen
// Row/column counters and the registered memory address for the input feeder.
// The address always runs one column ahead of col, because memory read data
// returns one cycle after the strobe.
//
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   op        : operation requested by the feeder FSM this cycle
//   row       : number of rows fully loaded in the current frame
//   col       : column being transferred in the current LOAD cycle
//   mem_addr  : registered word address row*INPUT_SIZE + column
// -----------------------------------------------------------------------------
module conv_layer_feeder_addr_gen
    import conv_layer_pkg::*;
#(
    parameter  int INPUT_SIZE = 8,
    parameter  int ADDR_WIDTH = 6,
    localparam int CNT_WIDTH  = $clog2(INPUT_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  addr_op_t              op,
    output logic [CNT_WIDTH-1:0]  row,
    output logic [CNT_WIDTH-1:0]  col,
    output logic [ADDR_WIDTH-1:0] mem_addr
);

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input int r, input int c);
        return ADDR_WIDTH'(r * INPUT_SIZE + c);
    endfunction

    // NOTE: registers are written with non-blocking assignments so every
    // always_ff block samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            mem_addr <= '0;
        end else begin
            case (op)
                ADDR_CLEAR: begin
                    row      <= '0;
                    col      <= '0;
                    mem_addr <= '0;
                end
                ADDR_BASE: begin
                    col      <= '0;
                    mem_addr <= word_addr(int'(row), 0);
                end
                ADDR_PREFETCH: begin
                    mem_addr <= word_addr(int'(row), int'(col) + 1);
                end
                ADDR_STEP: begin
                    col <= col + 1'b1;
                    // Past column INPUT_SIZE-1 there is nothing to read; holding
                    // the address keeps it from stepping into the next row.
                    if (int'(col) < INPUT_SIZE - 2)
                        mem_addr <= word_addr(int'(row), int'(col) + 2);
                end
                ADDR_NEXT_ROW: begin
                    col <= '0;
                    row <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_layer_input_feeder.sv
// -----------------------------------------------------------------------------
// conv_layer_input_feeder
// Fetches an INPUT_SIZE x INPUT_SIZE feature map from word-addressed memory and
// streams it row by row into the conv row buffer (LOAD), waiting for the
// buffer's load-finished ack after each row. Once KERNEL_SIZE rows are
// resident, it presents one KERNEL_SIZE-row window per loaded row (READ,
// buf_array_idx 0..KERNEL_SIZE-1) to the conv core.
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : frame start pulse, ignored unless idle
//   busy/done/error : frame in progress / end-of-frame pulse / sticky ack timeout
//   mem_rd_en,
//   mem_addr        : memory read strobe and address (row*INPUT_SIZE+col)
//   mem_rd_data     : read data, valid one cycle after mem_rd_en
//   buf_cmd         : row buffer command (INIT/IDLE/LOAD/READ)
//   buf_data        : word presented to the buffer during LOAD
//   buf_array_idx   : buffer array driving the buffer output bus
//   buf_ack         : buffer load-finished ack
//   row_valid,
//   row_ready       : window row handshake with the conv core
// All outputs are registered.
// -----------------------------------------------------------------------------
module conv_layer_input_feeder
    import conv_layer_pkg::*;
#(
    parameter int INPUT_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = 6,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [1:0]            buf_cmd,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic [1:0]            buf_array_idx,
    input  logic                  buf_ack,
    output logic                  row_valid,
    input  logic                  row_ready
);

    localparam int CNT_WIDTH = $clog2(INPUT_SIZE) + 1;
    localparam int TMO_WIDTH = $clog2(ACK_TIMEOUT) + 1;

    feeder_state_t        state;
    addr_op_t             addr_op;
    logic [CNT_WIDTH-1:0] row;
    logic [CNT_WIDTH-1:0] col;
    logic [TMO_WIDTH-1:0] ack_cnt;

    logic ack_seen;
    logic load_last;
    logic window_last;
    logic rows_primed;
    logic frame_end;
    logic to_fetch;

    conv_layer_feeder_addr_gen #(
        .INPUT_SIZE (INPUT_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .op       (addr_op),
        .row      (row),
        .col      (col),
        .mem_addr (mem_addr)
    );

    // Transition conditions shared by the FSM and the address generator, so
    // both agree on the cycle in which a new row fetch begins.
    // NOTE: every signal gets a value before any branch, so always_comb
    // never has a path that leaves a signal unassigned (no latch).
    always_comb begin
        ack_seen    = (buf_ack == ACK_LOAD_FIN);
        load_last   = (int'(col) == INPUT_SIZE - 1);
        window_last = row_ready && (int'(buf_array_idx) == KERNEL_SIZE - 1);
        rows_primed = (int'(row) >= KERNEL_SIZE);
        frame_end   = (int'(row) == INPUT_SIZE);
        to_fetch    = (state == ST_INIT)
                   || (state == ST_WAIT_ACK && ack_seen && !rows_primed)
                   || (state == ST_READ && window_last && !frame_end);

        addr_op = ADDR_HOLD;
        if (state == ST_IDLE && start)
            addr_op = ADDR_CLEAR;
        else if (to_fetch)
            addr_op = ADDR_BASE;
        else if (state == ST_FETCH)
            addr_op = ADDR_PREFETCH;
        else if (state == ST_LOAD)
            addr_op = load_last ? ADDR_NEXT_ROW : ADDR_STEP;
    end

    // Outputs are assigned on the edge that enters a state, so they hold the
    // values belonging to the state the FSM is currently in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            buf_cmd       <= CMD_INIT;
            buf_data      <= '0;
            buf_array_idx <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            mem_rd_en     <= 1'b0;
            row_valid     <= 1'b0;
            ack_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    buf_cmd <= CMD_IDLE;
                    if (start) begin
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        buf_cmd <= CMD_INIT;
                        state   <= ST_INIT;
                    end
                end

                ST_INIT: begin
                    buf_cmd   <= CMD_IDLE;
                    mem_rd_en <= 1'b1;
                    state     <= ST_FETCH;
                end

                ST_FETCH: begin
                    buf_cmd   <= CMD_LOAD;
                    mem_rd_en <= 1'b1;
                    state     <= ST_LOAD;
                end

                ST_LOAD: begin
                    buf_data  <= mem_rd_data;
                    // The read issued now returns for column col+2; stop once
                    // that would be past the end of the row.
                    mem_rd_en <= (int'(col) < INPUT_SIZE - 2);
                    if (load_last) begin
                        ack_cnt <= '0;
                        state   <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (ack_seen) begin
                        if (!rows_primed) begin
                            buf_cmd   <= CMD_IDLE;
                            mem_rd_en <= 1'b1;
                            state     <= ST_FETCH;
                        end else begin
                            buf_cmd       <= CMD_READ;
                            row_valid     <= 1'b1;
                            buf_array_idx <= '0;
                            state         <= ST_READ;
                        end
                    end else if (int'(ack_cnt) == ACK_TIMEOUT - 1) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        buf_cmd <= CMD_IDLE;
                        state   <= ST_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end

                ST_READ: begin
                    if (row_ready) begin
                        if (window_last) begin
                            row_valid <= 1'b0;
                            buf_cmd   <= CMD_IDLE;
                            if (frame_end) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                // The next LOAD shifts the buffer arrays up a row.
                                mem_rd_en <= 1'b1;
                                state     <= ST_FETCH;
                            end
                        end else begin
                            buf_array_idx <= buf_array_idx + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    buf_cmd <= CMD_IDLE;
                    state   <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_input_feeder.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_input_feeder
// Directed bench for conv_layer_input_feeder. Memory word k holds k; the bench
// plays the row buffer (ack) and the conv core (row_ready) in one linear
// sequence. Outputs are sampled and inputs driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_conv_layer_input_feeder;
    import conv_layer_pkg::*;

    localparam int N   = 8;
    localparam int K   = 3;
    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [1:0]    buf_cmd;
    logic [DW-1:0] buf_data;
    logic [1:0]    buf_array_idx;
    logic          buf_ack;
    logic          row_valid;
    logic          row_ready;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;

    conv_layer_input_feeder #(
        .INPUT_SIZE  (N),
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .buf_cmd       (buf_cmd),
        .buf_data      (buf_data),
        .buf_array_idx (buf_array_idx),
        .buf_ack       (buf_ack),
        .row_valid     (row_valid),
        .row_ready     (row_ready)
    );

    always #5 clk = ~clk;

    // Memory: word k = k, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= DW'(mem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (done === 1'b1)
            done_seen++;
    endtask

    // Entered on the FETCH cycle of row r; returns on the cycle after the ack
    // (FETCH or READ), or on the DONE cycle when ack_delay < 0 (no ack).
    task automatic load_row(input int r, input int ack_delay, input bit ack_in_load);
        check("fetch_cmd", 32'(buf_cmd), 32'(CMD_IDLE));
        check("fetch_rd_en", 32'(mem_rd_en), 1);
        check("fetch_addr", 32'(mem_addr), r * N);
        cyc();
        check("load_first_cmd", 32'(buf_cmd), 32'(CMD_LOAD));
        check("load_prefetch_addr", 32'(mem_addr), r * N + 1);
        for (int k = 0; k < N; k++) begin
            if (ack_in_load && k == 2) buf_ack = 1'b1;
            if (ack_in_load && k == 4) buf_ack = 1'b0;
            cyc();
            check("load_cmd", 32'(buf_cmd), 32'(CMD_LOAD));
            check("load_data", buf_data, r * N + k);
        end
        check("last_word_rd_en", 32'(mem_rd_en), 0);
        if (ack_delay < 0) begin
            for (int d = 1; d < TMO; d++) begin
                cyc();
                check("wait_no_error", 32'(error), 0);
                check("wait_cmd", 32'(buf_cmd), 32'(CMD_LOAD));
            end
            cyc();
            check("timeout_error", 32'(error), 1);
            check("timeout_done", 32'(done), 1);
            check("timeout_busy", 32'(busy), 0);
        end else begin
            for (int d = 0; d < ack_delay; d++) begin
                cyc();
                check("wait_cmd", 32'(buf_cmd), 32'(CMD_LOAD));
                check("wait_hold_data", buf_data, r * N + N - 1);
                check("wait_no_error", 32'(error), 0);
            end
            buf_ack = 1'b1;
            cyc();
            buf_ack = 1'b0;
        end
    endtask

    // Entered on the first READ cycle of a window; returns on the following
    // FETCH or DONE cycle.
    task automatic read_window(input bit stall, input bit poke_start);
        for (int i = 0; i < K; i++) begin
            check("read_cmd", 32'(buf_cmd), 32'(CMD_READ));
            check("read_valid", 32'(row_valid), 1);
            check("read_idx", 32'(buf_array_idx), i);
            if (stall && i == 1) begin
                row_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    cyc();
                    check("stall_idx", 32'(buf_array_idx), 1);
                    check("stall_valid", 32'(row_valid), 1);
                    check("stall_cmd", 32'(buf_cmd), 32'(CMD_READ));
                    check("stall_rd_en", 32'(mem_rd_en), 0);
                end
                row_ready = 1'b1;
            end
            if (poke_start && i == 0) start = 1'b1;
            cyc();
            start = 1'b0;
        end
    endtask

    task automatic run_frame(input int stall_win, input int late_row, input int dead_row,
                             input int poke_win, input int ack_load_row);
        int win;
        int done_before;
        win         = 0;
        done_before = done_seen;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("init_cmd", 32'(buf_cmd), 32'(CMD_INIT));
        check("init_busy", 32'(busy), 1);
        check("init_error", 32'(error), 0);
        cyc();
        for (int r = 0; r < N; r++) begin
            load_row(r, (r == late_row) ? 7 : ((r == dead_row) ? -1 : 1), r == ack_load_row);
            if (r == dead_row) begin
                check("timeout_one_done", done_seen, done_before + 1);
                cyc();
                check("timeout_idle_cmd", 32'(buf_cmd), 32'(CMD_IDLE));
                check("timeout_done_low", 32'(done), 0);
                check("timeout_error_sticky", 32'(error), 1);
                return;
            end
            if (r >= K - 1) begin
                win++;
                read_window(win == stall_win, win == poke_win);
            end
        end
        check("frame_done", 32'(done), 1);
        check("frame_done_busy", 32'(busy), 0);
        check("frame_error", 32'(error), 0);
        check("frame_done_cmd", 32'(buf_cmd), 32'(CMD_IDLE));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_done_busy", 32'(busy), 0);
            check("post_done_cmd", 32'(buf_cmd), 32'(CMD_IDLE));
        end
        check("frame_one_done", done_seen, done_before + 1);
    endtask

    initial begin
        int done_before;
        rst       = 1'b1;
        start     = 1'b0;
        buf_ack   = 1'b0;
        row_ready = 1'b1;

        // Reset state.
        cyc();
        cyc();
        check("rst_cmd", 32'(buf_cmd), 32'(CMD_INIT));
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_row_valid", 32'(row_valid), 0);
        check("rst_idx", 32'(buf_array_idx), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", buf_data, 0);
        rst = 1'b0;
        cyc();
        check("idle_cmd", 32'(buf_cmd), 32'(CMD_IDLE));
        check("idle_busy", 32'(busy), 0);

        // Full frame, prompt acks, row_ready high.
        run_frame(0, -1, -1, 0, -1);

        // Stall at idx 1 of window 2, 7-cycle late ack on row 1, ack held
        // during LOAD of row 0, start pulsed during READ of window 4.
        run_frame(2, 1, -1, 4, 0);

        // Buffer never acks row 4.
        run_frame(0, -1, 4, 0, -1);

        // Reset mid-LOAD at column 4 of row 2, with start raised alongside rst.
        done_before = done_seen;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart_clears_error", 32'(error), 0);
        cyc();
        load_row(0, 1, 1'b0);
        load_row(1, 1, 1'b0);
        check("row2_fetch_addr", 32'(mem_addr), 2 * N);
        cyc();
        for (int k = 0; k < 4; k++) cyc();
        check("pre_rst_data", buf_data, 2 * N + 3);
        rst   = 1'b1;
        start = 1'b1;
        cyc();
        check("midrst_cmd", 32'(buf_cmd), 32'(CMD_INIT));
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rd_en", 32'(mem_rd_en), 0);
        check("midrst_row_valid", 32'(row_valid), 0);
        check("midrst_addr", 32'(mem_addr), 0);
        cyc();
        check("rst_beats_start", 32'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("post_rst_cmd", 32'(buf_cmd), 32'(CMD_IDLE));
        check("post_rst_busy", 32'(busy), 0);
        check("midrst_no_done", done_seen, done_before);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_input_feeder.md
# conv_layer_input_feeder

Initiator for the conv layer input row buffer. It fetches an INPUT_SIZE x INPUT_SIZE feature map from a word-addressed memory and streams it row by row into the buffer with LOAD commands, waiting for the buffer's load-finished ack after each row. Once KERNEL_SIZE rows are resident, it sequences READ commands and array indices so the conv core can consume one KERNEL_SIZE-row window per loaded row. It sits between the input memory and the row buffer, under the layer controller.

## Interface
- INPUT_SIZE, 8: feature-map width and height in words.
- KERNEL_SIZE, 3: rows per window, which is also the number of buffer arrays.
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, 6: memory address width; must satisfy 2^ADDR_WIDTH >= INPUT_SIZE².
- ACK_TIMEOUT, 16: number of cycles allowed for buf_ack after the last word of a row.

Ports:
- clk, in, 1: the only clock. All logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse that begins a frame. Ignored while busy.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse at frame end.
- error, out, 1: sticky ack-timeout flag. Cleared by rst or by the next accepted start.
- mem_rd_en, out, 1: memory read strobe.
- mem_addr, out, ADDR_WIDTH: address, computed as row*INPUT_SIZE+col.
- mem_rd_data, in, DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.
- buf_cmd, out, 2: buffer command.
- buf_data, out, DATA_WIDTH: word presented to the buffer.
- buf_array_idx, out, 2: selects which buffer array drives the buffer's output bus.
- buf_ack, in, 1: buffer load-finished ack.
- row_valid, out, 1: the buffer output bus holds window row buf_array_idx.
- row_ready, in, 1: the conv core accepts the current row.

## Operation
The FSM has the states IDLE, INIT, FETCH, LOAD, WAIT_ACK, READ and DONE.

- **Reset:**
  - FSM goes to IDLE.
  - buf_cmd = CMD_INIT.
  - buf_data, buf_array_idx, mem_addr = 0.
  - busy, done, error, mem_rd_en, row_valid = 0.
  - Row and column counters = 0.
  - Reset mid-frame abandons the frame with no done pulse.
- **IDLE:** buf_cmd = CMD_IDLE. On start, clear error and the counters, then go to INIT.
- **INIT:** buf_cmd = CMD_INIT for exactly 1 cycle; the buffer clears all arrays. Then go to FETCH.
- **FETCH:** mem_rd_en = 1 with mem_addr = row*INPUT_SIZE, which prefetches column 0. buf_cmd = CMD_IDLE. Then go to LOAD.
- **LOAD:**
  - Lasts INPUT_SIZE cycles. buf_cmd = CMD_LOAD throughout.
  - buf_data = mem_rd_data for col = 0..INPUT_SIZE-1, one word per cycle with no gaps.
  - mem_rd_en stays high, addressing col+1, except in the final cycle.
  - After col = INPUT_SIZE-1, increment row and go to WAIT_ACK.
- **WAIT_ACK:**
  - buf_cmd stays CMD_LOAD and buf_data holds the last word.
  - When buf_ack = 1:
    - If row < KERNEL_SIZE, go to FETCH.
    - Otherwise go to READ with buf_array_idx = 0.
  - If ACK_TIMEOUT cycles pass without buf_ack, set error and go to DONE.
- **READ:**
  - buf_cmd = CMD_READ and row_valid = 1.
  - buf_array_idx steps 0, 1, …, KERNEL_SIZE-1, advancing only on a cycle where row_valid and row_ready are both high.
  - On acceptance of idx KERNEL_SIZE-1:
    - If row == INPUT_SIZE, go to DONE.
    - Otherwise go to FETCH; the next LOAD shifts the arrays up one row.
  - row_ready held low stalls indefinitely with all outputs stable.
- **DONE:** buf_cmd = CMD_IDLE, done = 1 for 1 cycle, busy drops in the same cycle. Then go to IDLE.
- **Counts per frame:** INPUT_SIZE row loads and INPUT_SIZE-KERNEL_SIZE+1 windows (6 with defaults).
- **Width rules:** mem_addr is row*INPUT_SIZE+col, truncated to ADDR_WIDTH; it never wraps when legally parameterised. col and row are $clog2(INPUT_SIZE)+1 bits wide.

## Timing
- From start to the first buf_cmd = CMD_LOAD: 3 cycles (IDLE→INIT→FETCH→LOAD).
- Each row load takes 1 FETCH cycle + INPUT_SIZE LOAD cycles + ack wait.
- start coinciding with rst: rst wins.
- buf_ack arriving during LOAD: ignored. Only WAIT_ACK samples buf_ack.
- All outputs are registered.

## Structure
- Shared package conv_layer_pkg holds:
  - CMD_INIT = 2'd0, CMD_IDLE = 2'd1, CMD_LOAD = 2'd2, CMD_READ = 2'd3.
  - ACK_LOAD_FIN = 1'b1.
  - The DATA_WIDTH default.
  - The FSM state encoding.
- One sub-module is natural: conv_layer_feeder_addr_gen, holding the row and column counters and the mem_addr computation.

## Test plan
- **Full frame:** Memory word k = k, the buffer model acks 1 cycle after the 8th word, and row_ready is tied high. Expected:
  - buf_data sequences are 0..7, 8..15, and so on through 56..63.
  - 6 windows, each with 3 READ idx cycles.
  - done after window 6; error = 0.
- **Row_ready stall:** Hold row_ready low for 10 cycles at idx 1 of window 2. buf_array_idx = 1, row_valid = 1 and buf_cmd = CMD_READ hold for all 10 cycles; no extra loads occur.
- **Ack timeout:** The buffer never acks row 4. error rises 16 cycles after the last word, done pulses, and the FSM returns to IDLE.
- **Reset mid-LOAD:** Assert rst at col 4 of row 2. On the next edge buf_cmd = CMD_INIT and busy, mem_rd_en, row_valid = 0. No done pulse.
- **start while busy:** Pulse start during READ. It is ignored and the frame completes with exactly 1 done.
- **Late ack:** The buffer acks 7 cycles after the last word. The FSM stays in WAIT_ACK; the next FETCH follows the ack by 1 cycle and error = 0.
